// File: rtl/niosii_system_sysid_pkg.sv
// Shared definitions for the system-ID checker: FSM encoding, sysid slave
// word addresses and the default expected image identity.
package niosii_system_sysid_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ID   = 3'd1,
        ST_RD_TS   = 3'd2,
        ST_COMPARE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam logic [31:0] DEFAULT_EXPECTED_ID        = 32'd0;
    localparam logic [31:0] DEFAULT_EXPECTED_TIMESTAMP = 32'd1486089823;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES     = 255;

endpackage

// File: rtl/niosii_system_sysid_checker.sv
// Avalon-MM read master that fetches the sysid ID and timestamp words after
// reset or on request, and reports sticky done/match/timeout status.
module niosii_system_sysid_checker
    import niosii_system_sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = DEFAULT_EXPECTED_ID,
    parameter logic [31:0] EXPECTED_TIMESTAMP = DEFAULT_EXPECTED_TIMESTAMP,
    parameter int unsigned TIMEOUT_CYCLES     = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic [31:0] id_value,
    output logic [31:0] timestamp_value,
    output logic        busy,
    output logic        done,
    output logic        match,
    output logic        timeout
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic             accept;
    logic             stall;
    logic             abort;

    assign accept = avm_read && !avm_waitrequest;
    assign stall  = avm_read && avm_waitrequest;
    assign abort  = stall && (wait_cnt == CNT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: state_next = ST_RD_ID;
            ST_RD_ID: begin
                if (accept) begin
                    state_next = ST_RD_TS;
                end else if (abort) begin
                    state_next = ST_DONE;
                end
            end
            ST_RD_TS: begin
                if (accept) begin
                    state_next = ST_COMPARE;
                end else if (abort) begin
                    state_next = ST_DONE;
                end
            end
            ST_COMPARE: state_next = ST_DONE;
            ST_DONE: begin
                if (start) begin
                    state_next = ST_RD_ID;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Bus strobes decode straight from the state register, so they stay
    // stable through a stall and drop at once on asynchronous reset.
    always_comb begin
        avm_read    = 1'b0;
        avm_address = SYSID_ADDR_ID;
        busy        = 1'b0;
        unique case (state)
            ST_RD_ID: begin
                avm_read = 1'b1;
                busy     = 1'b1;
            end
            ST_RD_TS: begin
                avm_read    = 1'b1;
                avm_address = SYSID_ADDR_TS;
                busy        = 1'b1;
            end
            ST_COMPARE: busy = 1'b1;
            default: begin
                avm_read    = 1'b0;
                avm_address = SYSID_ADDR_ID;
                busy        = 1'b0;
            end
        endcase
    end

    // Stall counter saturates instead of wrapping; any non-stalled cycle
    // (accept, abort, or not reading) returns it to zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
        end else if (stall && !abort) begin
            if (wait_cnt != CNT_MAX) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end else begin
            wait_cnt <= '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            id_value        <= '0;
            timestamp_value <= '0;
        end else begin
            if (state == ST_RD_ID && accept) begin
                id_value <= avm_readdata;
            end
            if (state == ST_RD_TS && accept) begin
                timestamp_value <= avm_readdata;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            done    <= 1'b0;
            match   <= 1'b0;
            timeout <= 1'b0;
        end else begin
            if (state == ST_COMPARE) begin
                done    <= 1'b1;
                match   <= (id_value == EXPECTED_ID) &&
                           (timestamp_value == EXPECTED_TIMESTAMP);
                timeout <= 1'b0;
            end else if (abort) begin
                done    <= 1'b1;
                match   <= 1'b0;
                timeout <= 1'b1;
            end else if (state == ST_DONE && start) begin
                done    <= 1'b0;
                match   <= 1'b0;
                timeout <= 1'b0;
            end
        end
    end

endmodule
